// File: rtl/irq_controller16_if.sv
// Interrupt controller bus: peripheral lines, CPU handshake and register access.
//   irq_src      16  level interrupt lines from peripherals (rising edge is an event)
//   mask_we      1   mask write strobe
//   mask_wdata   16  new mask value, bit=1 enables the source
//   pend_clr_we  1   pending-clear strobe
//   pend_clr     16  write-1-to-clear pending bits
//   irq_ack      1   CPU accepts the current request
//   irq_eoi      1   CPU end-of-interrupt
//   irq_req      1   request to CPU
//   irq_id       4   id of the requested / in-service source
//   in_service   1   a source is being serviced
//   pending      16  pending register
//   mask         16  mask register
interface irq_controller16_if;
  logic [15:0] irq_src;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        pend_clr_we;
  logic [15:0] pend_clr;
  logic        irq_ack;
  logic        irq_eoi;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        in_service;
  logic [15:0] pending;
  logic [15:0] mask;

  // Driver side (CPU plus peripherals).
  modport master (
    output irq_src, mask_we, mask_wdata, pend_clr_we, pend_clr, irq_ack, irq_eoi,
    input  irq_req, irq_id, in_service, pending, mask
  );

  // Controller side.
  modport slave (
    input  irq_src, mask_we, mask_wdata, pend_clr_we, pend_clr, irq_ack, irq_eoi,
    output irq_req, irq_id, in_service, pending, mask
  );
endinterface

// File: rtl/irq_controller16.sv
// 16-source edge-triggered interrupt controller with fixed priority (15 highest),
// a single request/service slot and no nesting.
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  irq_controller16_if.slave: source lines, mask/pending access, CPU handshake
module irq_controller16 (
  input logic                 clk,
  input logic                 rst,
  irq_controller16_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q;
  logic [15:0] pending_q, pending_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  id_q, id_d;

  logic [15:0] event_w;
  logic [15:0] active_w;
  logic [3:0]  winner_w;
  logic [15:0] ack_clr_w;
  logic [15:0] clr_w;

  assign event_w  = bus.irq_src & ~src_q;
  assign active_w = pending_q & mask_q;

  // Ascending scan so the highest enabled index is the one left standing.
  always_comb begin
    winner_w = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (active_w[i]) winner_w = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ack_clr_w = 16'h0000;
    unique case (state_q)
      StIdle: begin
        if (active_w != 16'h0000) begin
          state_d = StReq;
          id_d    = winner_w;
        end
      end
      StReq: begin
        // Ack takes precedence over withdrawal in the same cycle.
        if (bus.irq_ack) begin
          state_d   = StService;
          ack_clr_w = 16'h0001 << id_q;
        end else if (!(pending_q[id_q] && mask_q[id_q])) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (bus.irq_eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A new edge wins over any clear landing in the same cycle.
  assign clr_w     = (bus.pend_clr_we ? bus.pend_clr : 16'h0000) | ack_clr_w;
  assign pending_d = (pending_q & ~clr_w) | event_w;
  assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    // Sampled even in reset so lines held high across reset raise no event.
    src_q <= bus.irq_src;
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 16'h0000;
      mask_q    <= 16'h0000;
      id_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
    end
  end

  assign bus.irq_req    = (state_q == StReq);
  assign bus.in_service = (state_q == StService);
  assign bus.irq_id     = id_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_irq_controller16.sv
module tb_irq_controller16;

  logic clk;
  logic rst;
  irq_controller16_if bus();

  irq_controller16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = nothing outstanding, 1 = requesting, 2 = servicing.
  int          m_mode = 0;
  int          m_id   = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_mask = '0;
  logic [15:0] m_prev = '0;
  bit          model_valid = 0;

  function automatic int highest(logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic [15:0] ev, clr;
    ev     = bus.irq_src & ~m_prev;
    m_prev = bus.irq_src;
    if (rst) begin
      m_mode = 0; m_id = 0; m_pend = '0; m_mask = '0;
    end else begin
      clr = bus.pend_clr_we ? bus.pend_clr : 16'h0000;
      if (m_mode == 0) begin
        if ((m_pend & m_mask) != 0) begin
          m_mode = 1;
          m_id   = highest(m_pend & m_mask);
        end
      end else if (m_mode == 1) begin
        if (bus.irq_ack) begin
          m_mode = 2;
          clr[m_id] = 1'b1;
        end else if (!(m_pend[m_id] && m_mask[m_id])) begin
          m_mode = 0;
        end
      end else if (bus.irq_eoi) begin
        m_mode = 0;
      end
      m_pend = (m_pend & ~clr) | ev;
      if (bus.mask_we) m_mask = bus.mask_wdata;
    end
    model_valid = 1;
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_irq_req", 16'(bus.irq_req), 16'(m_mode == 1));
      chk("m_in_service", 16'(bus.in_service), 16'(m_mode == 2));
      chk("m_pending", bus.pending, m_pend);
      chk("m_mask", bus.mask, m_mask);
      if (m_mode != 0) chk("m_irq_id", 16'(bus.irq_id), 16'(m_id));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_mask(logic [15:0] m);
    bus.mask_we = 1'b1; bus.mask_wdata = m;
    cycle();
    bus.mask_we = 1'b0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1; cycle(); bus.irq_ack = 1'b0;
  endtask

  task automatic eoi();
    bus.irq_eoi = 1'b1; cycle(); bus.irq_eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_src = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.pend_clr_we = 0;
    bus.pend_clr = '0; bus.irq_ack = 0; bus.irq_eoi = 0;
    cycle(); cycle();
    chk("rst_pending", bus.pending, 16'h0000);
    chk("rst_mask", bus.mask, 16'h0000);
    chk("rst_id", 16'(bus.irq_id), 16'h0);
    chk("rst_req", 16'(bus.irq_req), 16'h0);
    chk("rst_insvc", 16'(bus.in_service), 16'h0);
    rst = 1'b0;
    set_mask(16'hFFFF);

    // Single source 3
    bus.irq_src = 16'h0008; cycle();
    chk("s3_pend", bus.pending, 16'h0008);
    chk("s3_req_lat1", 16'(bus.irq_req), 16'h0);
    cycle();
    chk("s3_req", 16'(bus.irq_req), 16'h1);
    chk("s3_id", 16'(bus.irq_id), 16'h3);
    ack();
    chk("s3_insvc", 16'(bus.in_service), 16'h1);
    chk("s3_pend_clr", bus.pending, 16'h0000);
    eoi();
    chk("s3_idle", 16'(bus.in_service | bus.irq_req), 16'h0);
    bus.irq_src = '0; cycle();

    // Sources 2 and 9 together
    bus.irq_src = 16'h0204; cycle(); cycle();
    chk("p9_id", 16'(bus.irq_id), 16'h9);
    chk("p9_req", 16'(bus.irq_req), 16'h1);
    ack(); eoi();
    chk("p_gap", 16'(bus.irq_req), 16'h0);
    cycle();
    chk("p2_id", 16'(bus.irq_id), 16'h2);
    chk("p2_req", 16'(bus.irq_req), 16'h1);
    ack(); eoi();
    bus.irq_src = '0; cycle();

    // No preemption while requesting
    bus.irq_src = 16'h0010; cycle(); cycle();
    chk("np4_id", 16'(bus.irq_id), 16'h4);
    bus.irq_src = 16'h1010; cycle(); cycle();
    chk("np_hold_id", 16'(bus.irq_id), 16'h4);
    chk("np_pend", bus.pending, 16'h1010);
    ack();
    chk("np_svc_id", 16'(bus.irq_id), 16'h4);
    chk("np_svc_pend", bus.pending, 16'h1000);
    eoi(); cycle();
    chk("np12_id", 16'(bus.irq_id), 16'hC);
    chk("np12_req", 16'(bus.irq_req), 16'h1);
    ack(); eoi();
    bus.irq_src = '0; cycle();

    // Masked pending, unmask, withdraw
    set_mask(16'h0000);
    bus.irq_src = 16'h0080; cycle(); cycle();
    chk("mk_pend", bus.pending, 16'h0080);
    chk("mk_noreq", 16'(bus.irq_req), 16'h0);
    set_mask(16'h0080);
    chk("mk_req_wait", 16'(bus.irq_req), 16'h0);
    cycle();
    chk("mk_req", 16'(bus.irq_req), 16'h1);
    chk("mk_id", 16'(bus.irq_id), 16'h7);
    set_mask(16'h0000);
    cycle();
    chk("wd_req", 16'(bus.irq_req), 16'h0);
    chk("wd_pend", bus.pending, 16'h0080);
    bus.pend_clr_we = 1; bus.pend_clr = 16'h0080; cycle();
    bus.pend_clr_we = 0; bus.pend_clr = '0;
    chk("wc_pend", bus.pending, 16'h0000);
    set_mask(16'hFFFF);
    bus.irq_src = '0; cycle();

    // New edge races ack clear and software clear
    bus.irq_src = 16'h0020; cycle();
    bus.irq_src = 16'h0000; cycle();
    chk("rc_req", 16'(bus.irq_req), 16'h1);
    bus.irq_src = 16'h0020; ack();
    chk("rc_ack_pend", bus.pending, 16'h0020);
    chk("rc_insvc", 16'(bus.in_service), 16'h1);
    bus.irq_src = 16'h0000; cycle();
    bus.pend_clr_we = 1; bus.pend_clr = 16'h0020; bus.irq_src = 16'h0020; cycle();
    bus.pend_clr_we = 0; bus.pend_clr = '0;
    chk("rc_clr_pend", bus.pending, 16'h0020);
    bus.irq_ack = 1'b1; cycle(); bus.irq_ack = 1'b0;
    chk("ack_ignored_pend", bus.pending, 16'h0020);
    eoi(); cycle(); ack(); eoi();
    bus.irq_src = '0; cycle();

    // Lines high across reset, reset during service
    rst = 1'b1; bus.irq_src = 16'hFFFF; cycle(); cycle();
    rst = 1'b0; cycle();
    chk("rr_pend", bus.pending, 16'h0000);
    set_mask(16'hFFFF); cycle();
    chk("rr_pend2", bus.pending, 16'h0000);
    chk("rr_req", 16'(bus.irq_req), 16'h0);
    bus.irq_src = '0; cycle();
    bus.irq_src = 16'h0001; cycle(); cycle(); ack();
    chk("rs_insvc", 16'(bus.in_service), 16'h1);
    rst = 1'b1; cycle();
    chk("rs_insvc0", 16'(bus.in_service), 16'h0);
    chk("rs_req0", 16'(bus.irq_req), 16'h0);
    chk("rs_id0", 16'(bus.irq_id), 16'h0);
    chk("rs_pend0", bus.pending, 16'h0000);
    chk("rs_mask0", bus.mask, 16'h0000);
    rst = 1'b0; cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller16.md
IRQ_CONTROLLER16 -- requirements
Module: irq_controller16

Interface
REQ-001 Parameters: none; width fixed at 16 sources, 4-bit id.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 irq_src  input  16  peripheral interrupt lines, level; a rising edge is an event.
REQ-005 mask_we  input  1  mask write strobe.
REQ-006 mask_wdata  input  16  new mask; bit=1 enables source.
REQ-007 pend_clr_we  input  1  pending-clear strobe.
REQ-008 pend_clr  input  16  write-1-to-clear pending bits.
REQ-009 irq_ack  input  1  CPU accepts current request.
REQ-010 irq_eoi  input  1  CPU end-of-interrupt.
REQ-011 irq_req  output  1  request to CPU; high only in REQ state.
REQ-012 irq_id  output  4  id of requested/in-service source.
REQ-013 in_service  output  1  high only in SERVICE state.
REQ-014 pending  output  16  pending register.
REQ-015 mask  output  16  mask register.

Function
REQ-016 Edge detect: src_q <= irq_src every cycle; event[i] = irq_src[i] & ~src_q[i].
REQ-017 pending next = (pending & ~clr) | event, where clr = pend_clr if pend_clr_we, plus ack-clear (REQ-022); event wins over any clear in the same cycle.
REQ-018 Events latch into pending regardless of mask.
REQ-019 Line high at a posedge with src_q=0 -> pending bit visible the following cycle (latency 1).
REQ-020 Priority: highest index among (pending & mask) wins; 15 highest, 0 lowest.
REQ-021 FSM states IDLE, REQ, SERVICE; IDLE -> REQ when (pending & mask) != 0, latching winner into irq_id on that edge; irq_req high the cycle after pending visible (event-to-request latency 2).
REQ-022 REQ -> SERVICE on irq_ack=1; same edge clears pending[irq_id] (subject to REQ-017).
REQ-023 REQ: irq_id held stable; higher-priority arrivals do not preempt.
REQ-024 REQ -> IDLE (withdraw) if pending[irq_id] & mask[irq_id] becomes 0 (masked or software-cleared) and irq_ack=0; if irq_ack=1 in that cycle, ack wins.
REQ-025 SERVICE -> IDLE on irq_eoi=1; irq_id holds value through SERVICE.
REQ-026 From IDLE after eoi, next request evaluated normally (one idle cycle minimum between requests).
REQ-027 irq_ack ignored outside REQ; irq_eoi ignored outside SERVICE.
REQ-028 Mask write: mask <= mask_wdata on mask_we, effective for arbitration next cycle.
REQ-029 No nesting: at most one source in service.

Reset
REQ-030 While rst=1: state IDLE, pending=0, mask=0, irq_id=0, irq_req=0, in_service=0, src_q <= irq_src (lines high across reset produce no event).
REQ-031 rst overrides all inputs including ack, eoi, mask_we; reset mid-REQ or mid-SERVICE drops to IDLE with pending cleared.

Verification
REQ-032 mask=FFFF, irq_src[3] rises at cycle 0 -> pending=0008 cycle 1, irq_req=1 irq_id=3 cycle 2; ack -> in_service=1, pending=0000; eoi -> IDLE.
REQ-033 Bits 2 and 9 rise same cycle, mask=FFFF -> irq_id=9 first; after ack/eoi, irq_id=2 requested.
REQ-034 In REQ with id=4, irq_src[12] rises -> irq_id stays 4 until ack; after eoi, id=12 requested.
REQ-035 mask=0000, irq_src[7] rises -> pending=0080, irq_req=0; write mask=0080 -> irq_req=1 irq_id=7 next cycle+1; then mask=0000 before ack -> withdraw, irq_req=0, pending still 0080.
REQ-036 irq_src[5] rises in same cycle ack clears pending[5] -> pending[5]=1 after; pend_clr=0020 with new edge on 5 -> pending[5]=1.
REQ-037 irq_src=FFFF held through rst release -> no pending bits; rst asserted during SERVICE -> all outputs zero next cycle.
